// File: rtl/digit_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_controller_pkg
//  Description : Shared display constants and digit-search helpers for the
//                multiplexed digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_scan_controller_pkg;

    // Widest display the helpers are sized for (16 digits, 4-bit index).
    localparam int MAX_DIGITS = 16;
    localparam int IDX_MAX_W  = 4;

    // Common-anode enables are active-low, so "all off" is all ones.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Brightness held in the latch while no slot has started yet.
    localparam int DEFAULT_BRIGHT = 0;

    // Lowest set bit of the mask; 0 when the mask is empty.
    function automatic logic [IDX_MAX_W-1:0] lowest_enabled_idx(
        input logic [MAX_DIGITS-1:0] mask
    );
        logic [IDX_MAX_W-1:0] r;
        r = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) r = IDX_MAX_W'(i);
        end
        return r;
    endfunction

    // Lowest enabled index strictly above idx, wrapping to the lowest enabled
    // index overall when nothing above is enabled.
    function automatic logic [IDX_MAX_W-1:0] next_enabled_idx(
        input logic [IDX_MAX_W-1:0]  idx,
        input logic [MAX_DIGITS-1:0] mask
    );
        logic [IDX_MAX_W-1:0] r;
        r = lowest_enabled_idx(mask);
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) r = IDX_MAX_W'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_controller
//  Description : Multiplexed common-anode display scanner with per-digit
//                masking, PWM brightness, inter-digit blanking, optional
//                skipping of disabled digits and a frame-start strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_controller
    import digit_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SEL_W         = 3,
    parameter int BRIGHT_W      = 4,
    parameter int BLANK_TICKS   = 1,
    parameter int SKIP_DISABLED = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  tick_i,
    input  logic [NUM_DIGITS-1:0] digit_en_i,
    input  logic [BRIGHT_W-1:0]   brightness_i,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic [SEL_W-1:0]      seg_sel_o,
    output logic                  frame_start_o
);

    localparam logic [BRIGHT_W-1:0]   SUB_MAX   = '1;
    localparam logic [BRIGHT_W-1:0]   BLANK_LIM = BRIGHT_W'(BLANK_TICKS);
    localparam logic [NUM_DIGITS-1:0] ANODE_RST = ANODE_OFF[NUM_DIGITS-1:0];

    logic [SEL_W-1:0]      idx_q,    idx_d;
    logic [BRIGHT_W-1:0]   sub_q,    sub_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [NUM_DIGITS-1:0] en_q,     en_d;
    logic                  first_q,  first_d;   // latch pending after reset
    logic [NUM_DIGITS-1:0] anode_q,  anode_d;
    logic                  frame_q,  frame_d;

    logic [MAX_DIGITS-1:0] mask_ext;
    logic [SEL_W-1:0]      first_digit;
    logic                  boundary;

    // Next-state and registered-output computation from the next-state values.
    always_comb begin
        idx_d       = idx_q;
        sub_d       = sub_q;
        bright_d    = bright_q;
        en_d        = en_q;
        first_d     = first_q;
        frame_d     = 1'b0;
        mask_ext    = MAX_DIGITS'(digit_en_i);
        boundary    = (sub_q == SUB_MAX);
        first_digit = (SKIP_DISABLED != 0) ? SEL_W'(lowest_enabled_idx(mask_ext)) : '0;

        if (tick_i) begin
            sub_d   = sub_q + BRIGHT_W'(1);
            first_d = 1'b0;
            // Brightness and mask only change at slot edges so a slot never
            // flickers mid-way; the first tick also latches them.
            if (boundary || first_q) begin
                bright_d = brightness_i;
                en_d     = digit_en_i;
            end
            if (boundary) begin
                if (int'(idx_q) >= NUM_DIGITS) begin
                    // Unreachable index (upset): recover to digit 0.
                    idx_d = '0;
                end else if (SKIP_DISABLED != 0) begin
                    if (digit_en_i == '0) idx_d = '0;
                    else idx_d = SEL_W'(next_enabled_idx(IDX_MAX_W'(idx_q), mask_ext));
                end else if (int'(idx_q) == NUM_DIGITS - 1) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
                frame_d = (idx_d == first_digit) &&
                          !((SKIP_DISABLED != 0) && (digit_en_i == '0));
            end
        end

        // Only the owning digit may light, and only inside its PWM window
        // after the blanking ticks.
        anode_d = ANODE_RST;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((int'(idx_d) == i) && en_d[i] && (sub_d >= BLANK_LIM) && (sub_d < bright_d))
                anode_d[i] = 1'b0;
        end
    end

    // State and output registers; reset is immediate and returns all dark.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q    <= '0;
            sub_q    <= '0;
            bright_q <= BRIGHT_W'(DEFAULT_BRIGHT);
            en_q     <= '0;
            first_q  <= 1'b1;
            anode_q  <= ANODE_RST;
            frame_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            sub_q    <= sub_d;
            bright_q <= bright_d;
            en_q     <= en_d;
            first_q  <= first_d;
            anode_q  <= anode_d;
            frame_q  <= frame_d;
        end
    end

    assign anode_o       = anode_q;
    assign seg_sel_o     = idx_q;
    assign frame_start_o = frame_q;

endmodule
`default_nettype wire
